// File: rtl/fitness_dispatch_if.sv
// Handshake and data bundle between the fitness dispatcher and its population
// memory, evaluator, and fitness memory.
interface fitness_dispatch_if #(
    parameter int LATTICE_LENGTH  = 11,
    parameter int DATA_WIDTH      = 4,
    parameter int SELF_FIT_LENGTH = 10,
    parameter int ADDR_WIDTH      = 6
);
    localparam int VEC_W = LATTICE_LENGTH * DATA_WIDTH;

    logic                       start_i;
    logic                       bank_i;
    logic                       pop_rd_en_o;
    logic [ADDR_WIDTH-1:0]      pop_rd_addr_o;
    logic [VEC_W-1:0]           pop_rd_data_i;
    logic                       set_data_o;
    logic                       in_valid_o;
    logic [VEC_W-1:0]           ind_vec_o;
    logic                       ind_idx_o;
    logic                       eval_valid_i;
    logic [SELF_FIT_LENGTH-1:0] eval_energy_i;
    logic                       eval_idx_i;
    logic                       fit_wr_en_o;
    logic [ADDR_WIDTH-1:0]      fit_wr_addr_o;
    logic [SELF_FIT_LENGTH-1:0] fit_wr_data_o;
    logic                       fit_wr_bank_o;
    logic [SELF_FIT_LENGTH-1:0] best_energy_o;
    logic [ADDR_WIDTH-1:0]      best_addr_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       proto_err_o;

    // Dispatcher side.
    modport master (
        input  start_i, bank_i, pop_rd_data_i, eval_valid_i, eval_energy_i, eval_idx_i,
        output pop_rd_en_o, pop_rd_addr_o, set_data_o, in_valid_o, ind_vec_o, ind_idx_o,
               fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o, fit_wr_bank_o,
               best_energy_o, best_addr_o, busy_o, done_o, proto_err_o
    );

    // Environment side: memories, evaluator and controller.
    modport slave (
        output start_i, bank_i, pop_rd_data_i, eval_valid_i, eval_energy_i, eval_idx_i,
        input  pop_rd_en_o, pop_rd_addr_o, set_data_o, in_valid_o, ind_vec_o, ind_idx_o,
               fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o, fit_wr_bank_o,
               best_energy_o, best_addr_o, busy_o, done_o, proto_err_o
    );
endinterface

// File: rtl/fitness_dispatch.sv
// Streams one generation of individuals to the fitness evaluator, writes the
// returned energies to fitness memory and tracks the generation minimum.
module fitness_dispatch #(
    parameter int POP_SIZE        = 50,
    parameter int LATTICE_LENGTH  = 11,
    parameter int DATA_WIDTH      = 4,
    parameter int SELF_FIT_LENGTH = 10,
    parameter int ADDR_WIDTH      = 6
) (
    input  logic               clk_i,
    input  logic               rst_n,
    fitness_dispatch_if.master disp
);
    localparam int VEC_W = LATTICE_LENGTH * DATA_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, CFG, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic             bank;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ok;
    logic             res_bad;

    // A result is accepted only inside a generation, below the population
    // count and tagged with the bank being evaluated; anything else is a fault.
    always_comb begin
        res_ok  = disp.eval_valid_i && (state != IDLE) &&
                  (res_cnt < CNT_W'(POP_SIZE)) && (disp.eval_idx_i == bank);
        res_bad = disp.eval_valid_i && !res_ok;
    end

    // Read data lands the cycle after the request, alongside in_valid_o.
    assign disp.ind_vec_o = disp.in_valid_o ? disp.pop_rd_data_i : {VEC_W{1'b0}};
    assign disp.ind_idx_o = bank;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            bank               <= 1'b0;
            res_cnt            <= '0;
            disp.pop_rd_en_o   <= 1'b0;
            disp.pop_rd_addr_o <= '0;
            disp.set_data_o    <= 1'b0;
            disp.in_valid_o    <= 1'b0;
            disp.fit_wr_en_o   <= 1'b0;
            disp.fit_wr_addr_o <= '0;
            disp.fit_wr_data_o <= '0;
            disp.fit_wr_bank_o <= 1'b0;
            disp.best_energy_o <= '0;
            disp.best_addr_o   <= '0;
            disp.busy_o        <= 1'b0;
            disp.done_o        <= 1'b0;
            disp.proto_err_o   <= 1'b0;
        end else begin
            disp.set_data_o  <= 1'b0;
            disp.done_o      <= 1'b0;
            disp.in_valid_o  <= disp.pop_rd_en_o;
            disp.fit_wr_en_o <= res_ok;

            // Result stage: write-back and running minimum, strict compare keeps ties early.
            if (res_ok) begin
                disp.fit_wr_addr_o <= ADDR_WIDTH'(res_cnt);
                disp.fit_wr_data_o <= disp.eval_energy_i;
                disp.fit_wr_bank_o <= disp.eval_idx_i;
                res_cnt            <= res_cnt + 1'b1;
                if (disp.eval_energy_i < disp.best_energy_o) begin
                    disp.best_energy_o <= disp.eval_energy_i;
                    disp.best_addr_o   <= ADDR_WIDTH'(res_cnt);
                end
            end

            case (state)
                IDLE: begin
                    if (disp.start_i) begin
                        bank               <= disp.bank_i;
                        res_cnt            <= '0;
                        disp.best_energy_o <= {SELF_FIT_LENGTH{1'b1}};
                        disp.best_addr_o   <= '0;
                        disp.proto_err_o   <= 1'b0;
                        disp.set_data_o    <= 1'b1;
                        disp.busy_o        <= 1'b1;
                        state              <= CFG;
                    end
                end
                CFG: begin
                    disp.pop_rd_en_o   <= 1'b1;
                    disp.pop_rd_addr_o <= '0;
                    state              <= ISSUE;
                end
                ISSUE: begin
                    if (disp.pop_rd_addr_o == ADDR_WIDTH'(POP_SIZE - 1)) begin
                        disp.pop_rd_en_o <= 1'b0;
                        state            <= DRAIN;
                    end else begin
                        disp.pop_rd_addr_o <= disp.pop_rd_addr_o + 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_cnt == CNT_W'(POP_SIZE)) begin
                        disp.done_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    disp.busy_o <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Sticky fault flag; also wins over the clear on a start cycle.
            if (res_bad) disp.proto_err_o <= 1'b1;
        end
    end
endmodule
